// File: rtl/splash_sequencer_pkg.sv
// splash_sequencer_pkg
//   Shared definitions for the end-of-game splash sequencer:
//   FSM state encoding, splash kind, scan / splash geometry defaults and a
//   saturating add used by the row-reveal wipe.
package splash_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_PLAY    = 3'd0,
        ST_WIPE    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_ARMED   = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    typedef enum logic {
        KIND_FAIL    = 1'b0,
        KIND_SUCCESS = 1'b1
    } kind_e;

    // Scan constants shared with the VGA timing and draw blocks.
    localparam int unsigned H_LAST_DEF      = 799;
    localparam int unsigned V_LAST_DEF      = 524;

    // Splash geometry / timing defaults.
    localparam int unsigned Y_OFFSET_DEF    = 120;
    localparam int unsigned ICON_HEIGHT_DEF = 240;
    localparam int unsigned WIPE_STEP_DEF   = 8;
    localparam int unsigned FRAME_HOLD_DEF  = 120;

    // a + b clamped to lim; carried out to 12 bits so the compare never wraps.
    function automatic logic [10:0] sat_add11(input logic [10:0] a,
                                              input logic [10:0] b,
                                              input logic [10:0] lim);
        logic [11:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, lim}) ? lim : s[10:0];
    endfunction

endpackage

// File: rtl/splash_sequencer_frame_tick_gen.sv
// frame_tick_gen
//   Emits a registered one-cycle pulse the cycle after the scan counters sit
//   on the last pixel of the frame. Reusable by timer / animation blocks.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   vert, horz    : current scan line / column
//   tick          : frame tick, high one cycle per frame
module frame_tick_gen #(
    parameter int unsigned H_LAST = 799,
    parameter int unsigned V_LAST = 524
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] vert,
    input  logic [9:0] horz,
    output logic       tick
);

    logic tick_d;
    logic tick_q;

    always_comb begin
        tick_d = (vert == 10'(V_LAST)) && (horz == 10'(H_LAST));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tick_q <= 1'b0;
        else       tick_q <= tick_d;
    end

    assign tick = tick_q;

endmodule

// File: rtl/splash_sequencer.sv
// splash_sequencer
//   Watches win/lose from the game core, freezes play, reveals the matching
//   splash with a top-down wipe (WIPE_STEP rows per frame), holds it for
//   FRAME_HOLD frames, then waits for a fresh button press and issues a
//   one-cycle restart. Unfreezes on the following frame tick.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   win, lose              : game-core event levels (only looked at in PLAY)
//   btn                    : debounced restart button level
//   vert, horz             : VGA scan counters
//   show_success/show_fail : splash drawer enables
//   reveal_row             : rows with vert < reveal_row are visible
//   game_freeze            : stalls player movement and timer
//   restart                : one-cycle game-core reset pulse
module splash_sequencer
    import splash_sequencer_pkg::*;
#(
    parameter int unsigned Y_OFFSET    = Y_OFFSET_DEF,
    parameter int unsigned ICON_HEIGHT = ICON_HEIGHT_DEF,
    parameter int unsigned WIPE_STEP   = WIPE_STEP_DEF,
    parameter int unsigned FRAME_HOLD  = FRAME_HOLD_DEF,
    parameter int unsigned H_LAST      = H_LAST_DEF,
    parameter int unsigned V_LAST      = V_LAST_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       win,
    input  logic       lose,
    input  logic       btn,
    input  logic [9:0] vert,
    input  logic [9:0] horz,
    output logic       show_success,
    output logic       show_fail,
    output logic [9:0] reveal_row,
    output logic       game_freeze,
    output logic       restart
);

    localparam logic [10:0] REVEAL_LIM = 11'(Y_OFFSET + ICON_HEIGHT);
    localparam logic [9:0]  REVEAL_RST = 10'(Y_OFFSET);
    localparam logic [10:0] STEP11     = 11'(WIPE_STEP);
    localparam logic [7:0]  HOLD_LAST  = 8'(FRAME_HOLD - 1);

    logic tick;

    frame_tick_gen #(
        .H_LAST (H_LAST),
        .V_LAST (V_LAST)
    ) u_frame_tick_gen (
        .clk   (clk),
        .reset (reset),
        .vert  (vert),
        .horz  (horz),
        .tick  (tick)
    );

    state_e      state_q,        state_d;
    kind_e       kind_q,         kind_d;
    logic [9:0]  reveal_q,       reveal_d;
    logic [7:0]  hold_cnt_q,     hold_cnt_d;
    // Input sampling stage: events act one cycle after they are registered.
    logic        win_q,          win_d;
    logic        lose_q,         lose_d;
    logic        btn_q,          btn_d;
    logic        btn_prev_q,     btn_prev_d;
    logic        show_success_q, show_success_d;
    logic        show_fail_q,    show_fail_d;
    logic        game_freeze_q,  game_freeze_d;
    logic        restart_q,      restart_d;

    logic        btn_rise;
    logic [10:0] wipe_sum;

    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        reveal_d       = reveal_q;
        hold_cnt_d     = hold_cnt_q;
        show_success_d = show_success_q;
        show_fail_d    = show_fail_q;
        game_freeze_d  = game_freeze_q;
        restart_d      = 1'b0;

        win_d      = win;
        lose_d     = lose;
        btn_d      = btn;
        // History tracks in every state, so a button already held when
        // ARMED is entered shows no rising edge.
        btn_prev_d = btn_q;
        btn_rise   = btn_q & ~btn_prev_q;

        wipe_sum = sat_add11({1'b0, reveal_q}, STEP11, REVEAL_LIM);

        case (state_q)
            ST_PLAY: begin
                if (win_q || lose_q) begin
                    // success takes priority when both arrive together
                    state_d        = ST_WIPE;
                    kind_d         = win_q ? KIND_SUCCESS : KIND_FAIL;
                    show_success_d = win_q;
                    show_fail_d    = ~win_q;
                    game_freeze_d  = 1'b1;
                    reveal_d       = REVEAL_RST;
                end
            end
            ST_WIPE: begin
                show_success_d = (kind_q == KIND_SUCCESS);
                show_fail_d    = (kind_q == KIND_FAIL);
                if (tick) begin
                    reveal_d = wipe_sum[9:0];
                    if (wipe_sum == REVEAL_LIM) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = 8'd0;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                    if (hold_cnt_q == HOLD_LAST) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (btn_rise) begin
                    state_d        = ST_RELEASE;
                    restart_d      = 1'b1;
                    show_success_d = 1'b0;
                    show_fail_d    = 1'b0;
                    reveal_d       = REVEAL_RST;
                end
            end
            ST_RELEASE: begin
                // keep play frozen until a frame boundary
                if (tick) begin
                    state_d       = ST_PLAY;
                    game_freeze_d = 1'b0;
                end
            end
            default: begin
                state_d        = ST_PLAY;
                show_success_d = 1'b0;
                show_fail_d    = 1'b0;
                game_freeze_d  = 1'b0;
                reveal_d       = REVEAL_RST;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_PLAY;
            kind_q         <= KIND_FAIL;
            reveal_q       <= REVEAL_RST;
            hold_cnt_q     <= 8'd0;
            win_q          <= 1'b0;
            lose_q         <= 1'b0;
            btn_q          <= 1'b0;
            btn_prev_q     <= 1'b0;
            show_success_q <= 1'b0;
            show_fail_q    <= 1'b0;
            game_freeze_q  <= 1'b0;
            restart_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            reveal_q       <= reveal_d;
            hold_cnt_q     <= hold_cnt_d;
            win_q          <= win_d;
            lose_q         <= lose_d;
            btn_q          <= btn_d;
            btn_prev_q     <= btn_prev_d;
            show_success_q <= show_success_d;
            show_fail_q    <= show_fail_d;
            game_freeze_q  <= game_freeze_d;
            restart_q      <= restart_d;
        end
    end

    assign show_success = show_success_q;
    assign show_fail    = show_fail_q;
    assign reveal_row   = reveal_q;
    assign game_freeze  = game_freeze_q;
    assign restart      = restart_q;

endmodule

// File: tb/tb_splash_sequencer.sv
// Bench for splash_sequencer: two instances (WIPE_STEP 8 and 7) share random
// stimulus on a shortened scan; each is compared every cycle with a
// frame-counting reference model.
module tb_splash_sequencer;

    localparam int HL   = 7;
    localparam int VL   = 4;
    localparam int YO   = 120;
    localparam int IH   = 240;
    localparam int FH   = 4;
    localparam int NCYC = 30000;

    logic       clk = 1'b0;
    logic       reset;
    logic       win, lose, btn;
    logic [9:0] vert, horz;

    logic [1:0] o_ss, o_sf, o_frz, o_rst;
    logic [9:0] o_row [2];

    always #5 clk = ~clk;

    splash_sequencer #(.Y_OFFSET(YO), .ICON_HEIGHT(IH), .WIPE_STEP(8),
                       .FRAME_HOLD(FH), .H_LAST(HL), .V_LAST(VL)) u_dut8 (
        .clk(clk), .reset(reset), .win(win), .lose(lose), .btn(btn),
        .vert(vert), .horz(horz),
        .show_success(o_ss[0]), .show_fail(o_sf[0]), .reveal_row(o_row[0]),
        .game_freeze(o_frz[0]), .restart(o_rst[0]));

    splash_sequencer #(.Y_OFFSET(YO), .ICON_HEIGHT(IH), .WIPE_STEP(7),
                       .FRAME_HOLD(FH), .H_LAST(HL), .V_LAST(VL)) u_dut7 (
        .clk(clk), .reset(reset), .win(win), .lose(lose), .btn(btn),
        .vert(vert), .horz(horz),
        .show_success(o_ss[1]), .show_fail(o_sf[1]), .reveal_row(o_row[1]),
        .game_freeze(o_frz[1]), .restart(o_rst[1]));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. Modes: 0 playing, 1 revealing, 2 holding,
    // 3 waiting for press, 4 leaving. Visible rows derive from frames seen.
    int step [2] = '{8, 7};
    int m_mode [2], m_frames [2], m_held [2], m_succ [2], m_age [2];
    int n_rst [2];
    bit m_w1, m_l1, m_b1, m_b2, m_t1;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_frames[i] = 0; m_held[i] = 0; m_succ[i] = 0; m_age[i] = 0;
        end
        m_w1 = 0; m_l1 = 0; m_b1 = 0; m_b2 = 0; m_t1 = 0;
    endtask

    // Called after each active edge with the inputs that edge sampled.
    task automatic model_step();
        bit rise;
        rise = m_b1 && !m_b2;
        for (int i = 0; i < 2; i++) begin
            case (m_mode[i])
                0: if (m_w1 || m_l1) begin
                       m_mode[i] = 1; m_succ[i] = m_w1 ? 1 : 0; m_frames[i] = 0;
                   end
                1: if (m_t1) begin
                       m_frames[i]++;
                       if (YO + m_frames[i] * step[i] >= YO + IH) begin
                           m_mode[i] = 2; m_held[i] = 0;
                       end
                   end
                2: if (m_t1) begin
                       m_held[i]++;
                       if (m_held[i] == FH) m_mode[i] = 3;
                   end
                3: if (rise) begin
                       m_mode[i] = 4; m_age[i] = 0; n_rst[i]++;
                   end
                default: begin
                       m_age[i]++;
                       if (m_t1) m_mode[i] = 0;
                   end
            endcase
        end
        m_b2 = m_b1;
        m_b1 = btn;
        m_w1 = win;
        m_l1 = lose;
        m_t1 = (vert == 10'(VL)) && (horz == 10'(HL));
    endtask

    function automatic int exp_row(input int i);
        int r;
        if (m_mode[i] < 1 || m_mode[i] > 3) return YO;
        r = YO + m_frames[i] * step[i];
        return (r > YO + IH) ? YO + IH : r;
    endfunction

    task automatic check_outputs();
        bit shown;
        for (int i = 0; i < 2; i++) begin
            shown = (m_mode[i] >= 1 && m_mode[i] <= 3);
            chk($sformatf("succ%0d", i), 32'(o_ss[i]),  32'(shown && m_succ[i] == 1));
            chk($sformatf("fail%0d", i), 32'(o_sf[i]),  32'(shown && m_succ[i] == 0));
            chk($sformatf("frz%0d", i),  32'(o_frz[i]), 32'(m_mode[i] != 0));
            chk($sformatf("rst%0d", i),  32'(o_rst[i]), 32'(m_mode[i] == 4 && m_age[i] == 0));
            chk($sformatf("row%0d", i),  32'(o_row[i]), 32'(exp_row(i)));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_succ%0d", tag, i), 32'(o_ss[i]),  32'd0);
            chk($sformatf("%s_fail%0d", tag, i), 32'(o_sf[i]),  32'd0);
            chk($sformatf("%s_frz%0d", tag, i),  32'(o_frz[i]), 32'd0);
            chk($sformatf("%s_rst%0d", tag, i),  32'(o_rst[i]), 32'd0);
            chk($sformatf("%s_row%0d", tag, i),  32'(o_row[i]), 32'(YO));
        end
    endtask

    bit sim_done = 0;
    bit rst_done = 0;

    initial begin
        reset = 1'b1; win = 1'b0; lose = 1'b0; btn = 1'b0;
        vert = '0; horz = '0;
        n_rst[0] = 0; n_rst[1] = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outputs();

            // Asynchronous reset in the middle of HOLD, between clock edges.
            if (!rst_done && m_mode[0] == 2 && m_held[0] == 1) begin
                rst_done = 1;
                #2 reset = 1'b1;
                #1 check_reset_vals("async");
                model_reset();
                repeat (2) @(negedge clk);
                check_reset_vals("inrst");
                reset = 1'b0;
            end

            if (horz == 10'(HL)) begin
                horz = '0;
                vert = (vert == 10'(VL)) ? '0 : vert + 10'd1;
            end else begin
                horz = horz + 10'd1;
            end

            if (!sim_done && cyc > 50 && m_mode[0] == 0 && m_mode[1] == 0) begin
                win = 1'b1; lose = 1'b1; sim_done = 1;
            end else begin
                win  = ($urandom_range(0, 39) == 0);
                lose = ($urandom_range(0, 39) == 0);
            end
            if ($urandom_range(0, 24) == 0) btn = ~btn;
        end

        chk("restarts8", 32'(n_rst[0] >= 2), 32'd1);
        chk("restarts7", 32'(n_rst[1] >= 2), 32'd1);
        chk("async_seen", 32'(rst_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
